// File: rtl/aud_record_writer_if.sv
// Record-writer bus: control pulses and ADC samples in, SRAM write port and status out.
// Pure wiring, no latency of its own.
// No backpressure: samples are one-cycle pulses, and the writer drops any that arrive while it is busy.
interface aud_record_writer_if;
  logic        i_start;
  logic        i_pause;
  logic        i_stop;
  logic        i_data_valid;
  logic [15:0] i_data;
  logic [19:0] o_sram_addr;
  logic [15:0] o_sram_data;
  logic        o_sram_we_n;
  logic        o_busy;
  logic        o_full;
  logic        o_overrun;
  logic [19:0] o_rec_len;

  modport master (
    output i_start, i_pause, i_stop, i_data_valid, i_data,
    input  o_sram_addr, o_sram_data, o_sram_we_n, o_busy, o_full, o_overrun, o_rec_len
  );

  modport slave (
    input  i_start, i_pause, i_stop, i_data_valid, i_data,
    output o_sram_addr, o_sram_data, o_sram_we_n, o_busy, o_full, o_overrun, o_rec_len
  );
endinterface

// File: rtl/aud_record_writer.sv
// Writes ADC samples sequentially into the SRAM recording region under start/pause/stop control.
// Latency: a sample pulse at cycle n drives we_n low with its data at n+1, for WE_CYCLES cycles, followed by one hold cycle.
// No backpressure: a sample arriving during a write is dropped and flagged in the sticky overrun bit.
module aud_record_writer #(
  parameter logic [19:0] ADDR_MIN  = 20'h00000,
  parameter logic [19:0] ADDR_MAX  = 20'h143BF,
  parameter int          WE_CYCLES = 2
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  aud_record_writer_if.slave bus
);

  localparam int CW = (WE_CYCLES > 1) ? $clog2(WE_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT, S_WRITE, S_HOLD, S_PAUSE, S_DONE
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] we_cnt;
  logic          pend_stop;
  logic          pend_pause;
  logic          we_last;
  logic          at_max;
  logic          stop_now;
  logic          pause_now;
  logic          start_go;

  assign we_last   = (we_cnt == CW'(WE_CYCLES - 1));
  assign at_max    = (bus.o_sram_addr == ADDR_MAX);
  // A pulse landing in the HOLD cycle itself counts just like one registered during WRITE.
  assign stop_now  = pend_stop | bus.i_stop;
  assign pause_now = pend_pause | bus.i_pause;
  // Stop and pause outrank start when pulses coincide.
  assign start_go  = bus.i_start & ~bus.i_stop & ~bus.i_pause;

  assign bus.o_busy = (state != S_IDLE) && (state != S_DONE);
  assign bus.o_full = (state == S_DONE);

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  // Next-state resolution; a write once started always runs through WRITE and HOLD.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start_go) state_nxt = S_WAIT;
      S_WAIT: begin
        if (bus.i_stop)            state_nxt = S_IDLE;
        else if (bus.i_pause)      state_nxt = S_PAUSE;
        else if (bus.i_data_valid) state_nxt = S_WRITE;
      end
      S_WRITE: if (we_last) state_nxt = S_HOLD;
      S_HOLD: begin
        if (stop_now)       state_nxt = S_IDLE;
        else if (at_max)    state_nxt = S_DONE;
        else if (pause_now) state_nxt = S_PAUSE;
        else                state_nxt = S_WAIT;
      end
      S_PAUSE: begin
        if (bus.i_stop)    state_nxt = S_IDLE;
        else if (start_go) state_nxt = S_WAIT;
      end
      S_DONE: begin
        if (bus.i_stop)    state_nxt = S_IDLE;
        else if (start_go) state_nxt = S_WAIT;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // SRAM port, length counter, pending controls and overrun flag; later assignments take precedence.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      bus.o_sram_addr <= ADDR_MIN;
      bus.o_sram_data <= 16'h0000;
      bus.o_sram_we_n <= 1'b1;
      bus.o_overrun   <= 1'b0;
      bus.o_rec_len   <= 20'h00000;
      we_cnt          <= '0;
      pend_stop       <= 1'b0;
      pend_pause      <= 1'b0;
    end else begin
      case (state)
        S_WAIT: begin
          if (state_nxt == S_WRITE) begin
            bus.o_sram_data <= bus.i_data;
            bus.o_sram_we_n <= 1'b0;
            we_cnt          <= '0;
          end
        end
        S_WRITE: begin
          if (we_last) bus.o_sram_we_n <= 1'b1;
          else         we_cnt          <= we_cnt + 1'b1;
        end
        S_HOLD: begin
          bus.o_rec_len <= bus.o_sram_addr - ADDR_MIN + 20'd1;
          if (!at_max) bus.o_sram_addr <= bus.o_sram_addr + 20'd1;
          pend_stop  <= 1'b0;
          pend_pause <= 1'b0;
        end
        default: ;
      endcase

      // Controls seen mid-write are deferred to HOLD exit; samples seen mid-write are lost.
      if (state == S_WRITE) begin
        if (bus.i_stop)  pend_stop  <= 1'b1;
        if (bus.i_pause) pend_pause <= 1'b1;
      end
      if ((state == S_WRITE || state == S_HOLD) && bus.i_data_valid)
        bus.o_overrun <= 1'b1;

      // A fresh recording clears length and overrun and rewinds to the region start.
      if ((state == S_IDLE || state == S_DONE) && state_nxt == S_WAIT) begin
        bus.o_rec_len   <= 20'h00000;
        bus.o_overrun   <= 1'b0;
        bus.o_sram_addr <= ADDR_MIN;
      end
      if (state_nxt == S_IDLE) bus.o_sram_addr <= ADDR_MIN;
    end
  end

endmodule

// File: tb/tb_aud_record_writer.sv
// Scoreboard bench for aud_record_writer: expected SRAM writes and status snapshots are queued
// by the stimulus; a negedge monitor checks every we_n-low window and every requested snapshot.
// The region is shrunk to 4 words so the full/no-wrap behaviour is reachable.
module tb_aud_record_writer;

  typedef struct packed {
    logic [19:0] addr;
    logic [15:0] data;
  } wr_t;

  typedef struct packed {
    logic        busy;
    logic        full;
    logic        ovr;
    logic        we_n;
    logic [19:0] rec_len;
    logic [19:0] addr;
  } st_t;

  logic clk;
  logic rst_n;
  logic chk_req;
  int   checks;
  int   errors;
  wr_t  wq[$];
  st_t  sq[$];

  aud_record_writer_if bus();

  aud_record_writer #(
    .ADDR_MIN (20'h00000),
    .ADDR_MAX (20'h00003),
    .WE_CYCLES(2)
  ) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: checks write windows and requested status snapshots on the falling edge.
  initial begin
    bit   in_win;
    int   win_len;
    wr_t  cur;
    wr_t  exp_w;
    st_t  exp_s;
    st_t  act_s;
    in_win  = 1'b0;
    win_len = 0;
    cur     = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        in_win = 1'b0;
      end else if (!bus.o_sram_we_n) begin
        if (!in_win) begin
          in_win   = 1'b1;
          win_len  = 1;
          cur.addr = bus.o_sram_addr;
          cur.data = bus.o_sram_data;
          checks++;
          if (wq.size() == 0) begin
            errors++;
            $display("FAIL write_unexpected: got addr=%h data=%h, required no write", cur.addr, cur.data);
          end else begin
            exp_w = wq.pop_front();
            if (cur !== exp_w) begin
              errors++;
              $display("FAIL write_addr_data: got addr=%h data=%h, required addr=%h data=%h",
                       cur.addr, cur.data, exp_w.addr, exp_w.data);
            end
          end
        end else begin
          win_len++;
          checks++;
          if (bus.o_sram_addr !== cur.addr || bus.o_sram_data !== cur.data) begin
            errors++;
            $display("FAIL write_stable: got addr=%h data=%h, required addr=%h data=%h",
                     bus.o_sram_addr, bus.o_sram_data, cur.addr, cur.data);
          end
        end
      end else if (in_win) begin
        in_win = 1'b0;
        checks++;
        if (win_len != 2 || bus.o_sram_addr !== cur.addr || bus.o_sram_data !== cur.data) begin
          errors++;
          $display("FAIL write_window_hold: got len=%0d addr=%h data=%h, required len=2 addr=%h data=%h",
                   win_len, bus.o_sram_addr, bus.o_sram_data, cur.addr, cur.data);
        end
      end

      if (chk_req) begin
        act_s = {bus.o_busy, bus.o_full, bus.o_overrun, bus.o_sram_we_n, bus.o_rec_len, bus.o_sram_addr};
        checks++;
        if (sq.size() == 0) begin
          errors++;
          $display("FAIL status_queue: got empty queue, required a queued expectation");
        end else begin
          exp_s = sq.pop_front();
          if (act_s !== exp_s) begin
            errors++;
            $display("FAIL status: got busy=%b full=%b ovr=%b we_n=%b len=%0d addr=%h, required busy=%b full=%b ovr=%b we_n=%b len=%0d addr=%h",
                     act_s.busy, act_s.full, act_s.ovr, act_s.we_n, act_s.rec_len, act_s.addr,
                     exp_s.busy, exp_s.full, exp_s.ovr, exp_s.we_n, exp_s.rec_len, exp_s.addr);
          end
        end
        checks++;
        if (wq.size() != 0) begin
          errors++;
          $display("FAIL writes_missing: got %0d outstanding writes, required 0", wq.size());
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    bus.i_start = 1'b1; tick(1); bus.i_start = 1'b0;
  endtask

  task automatic pulse_pause();
    bus.i_pause = 1'b1; tick(1); bus.i_pause = 1'b0;
  endtask

  task automatic pulse_stop();
    bus.i_stop = 1'b1; tick(1); bus.i_stop = 1'b0;
  endtask

  task automatic send(input logic [15:0] d, input bit exp, input logic [19:0] a);
    if (exp) wq.push_back('{addr: a, data: d});
    bus.i_data_valid = 1'b1;
    bus.i_data       = d;
    tick(1);
    bus.i_data_valid = 1'b0;
  endtask

  task automatic expst(input logic busy, input logic full, input logic ovr,
                       input logic [19:0] len, input logic [19:0] addr, input logic we_n);
    sq.push_back('{busy: busy, full: full, ovr: ovr, we_n: we_n, rec_len: len, addr: addr});
    chk_req = 1'b1;
    tick(1);
    chk_req = 1'b0;
  endtask

  initial begin
    checks           = 0;
    errors           = 0;
    chk_req          = 1'b0;
    rst_n            = 1'b0;
    bus.i_start      = 1'b0;
    bus.i_pause      = 1'b0;
    bus.i_stop       = 1'b0;
    bus.i_data_valid = 1'b0;
    bus.i_data       = 16'h0000;

    // Reset state.
    tick(2);
    expst(1'b0, 1'b0, 1'b0, 20'd0, 20'h0, 1'b1);
    rst_n = 1'b1;
    tick(2);

    // Basic write: three samples, ten cycles apart.
    pulse_start();
    tick(2);
    send(16'h1234, 1'b1, 20'h0); tick(9);
    send(16'h8001, 1'b1, 20'h1); tick(9);
    send(16'h7FFF, 1'b1, 20'h2); tick(9);
    expst(1'b1, 1'b0, 1'b0, 20'd3, 20'h3, 1'b1);
    pulse_stop(); tick(2);
    expst(1'b0, 1'b0, 1'b0, 20'd3, 20'h0, 1'b1);

    // Pause/resume: samples during pause are neither written nor counted as overrun.
    pulse_start(); tick(2);
    send(16'hAAAA, 1'b1, 20'h0); tick(9);
    send(16'h5555, 1'b1, 20'h1); tick(9);
    pulse_pause(); tick(2);
    for (int i = 0; i < 5; i++) begin
      send(16'hDEAD, 1'b0, 20'h0); tick(2);
    end
    expst(1'b1, 1'b0, 1'b0, 20'd2, 20'h2, 1'b1);
    pulse_start(); tick(2);
    send(16'h0F0F, 1'b1, 20'h2); tick(9);
    expst(1'b1, 1'b0, 1'b0, 20'd3, 20'h3, 1'b1);
    pulse_stop(); tick(2);
    expst(1'b0, 1'b0, 1'b0, 20'd3, 20'h0, 1'b1);

    // Stop in the cycle after we_n falls: the write completes, HOLD follows, then IDLE.
    pulse_start(); tick(2);
    send(16'h4242, 1'b1, 20'h0);
    tick(1);
    pulse_stop();
    expst(1'b1, 1'b0, 1'b0, 20'd0, 20'h0, 1'b1);
    tick(2);
    expst(1'b0, 1'b0, 1'b0, 20'd1, 20'h0, 1'b1);

    // Region full: four words written, later samples ignored, no wrap.
    pulse_start(); tick(2);
    for (int i = 0; i < 6; i++) begin
      send(16'h1000 + 16'(i), (i < 4), 20'(i)); tick(5);
    end
    expst(1'b0, 1'b1, 1'b0, 20'd4, 20'h3, 1'b1);
    pulse_start();
    expst(1'b1, 1'b0, 1'b0, 20'd0, 20'h0, 1'b1);
    send(16'hBEEF, 1'b1, 20'h0); tick(6);
    expst(1'b1, 1'b0, 1'b0, 20'd1, 20'h1, 1'b1);
    pulse_stop(); tick(2);

    // Overrun: a second sample two cycles after the first is dropped; the flag is sticky.
    pulse_start(); tick(2);
    send(16'h1111, 1'b1, 20'h0);
    tick(1);
    send(16'h2222, 1'b0, 20'h0);
    tick(6);
    expst(1'b1, 1'b0, 1'b1, 20'd1, 20'h1, 1'b1);
    send(16'h3333, 1'b1, 20'h1); tick(6);
    expst(1'b1, 1'b0, 1'b1, 20'd2, 20'h2, 1'b1);
    pulse_stop(); tick(2);
    expst(1'b0, 1'b0, 1'b1, 20'd2, 20'h0, 1'b1);
    pulse_start();
    expst(1'b1, 1'b0, 1'b0, 20'd0, 20'h0, 1'b1);

    // Async reset in the middle of the second write.
    tick(1);
    send(16'h5A5A, 1'b1, 20'h0); tick(6);
    send(16'hA5A5, 1'b1, 20'h1);
    tick(1);
    #1;
    rst_n = 1'b0;
    expst(1'b0, 1'b0, 1'b0, 20'd0, 20'h0, 1'b1);
    rst_n = 1'b1;
    tick(4);
    expst(1'b0, 1'b0, 1'b0, 20'd0, 20'h0, 1'b1);

    tick(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/aud_record_writer.md
Name: aud_record_writer

Overview:
Record-side counterpart of the playback DSP. It takes 16-bit signed samples from the I2S ADC receiver (one valid pulse per sample) and writes them sequentially into the shared SRAM recording region. It is controlled by the same start/pause/stop key pulses as playback. It reports the recorded length so the playback path knows where valid data ends.

Parameters:
ADDR_MIN, 20'h00000, first SRAM word of the recording region
ADDR_MAX, 20'h143BF, last SRAM word of the recording region (inclusive)
WE_CYCLES, 2, number of cycles o_sram_we_n is held low per write (>=1)

Ports:
i_clk  input  1  system clock
i_rst_n  input  1  reset; asynchronous, active-low
i_start  input  1  one-cycle pulse: start, or resume from pause
i_pause  input  1  one-cycle pulse: pause recording
i_stop  input  1  one-cycle pulse: stop recording
i_data_valid  input  1  one-cycle pulse; i_data holds a new ADC sample
i_data  input  16  signed ADC sample
o_sram_addr  output  20  SRAM write address
o_sram_data  output  16  SRAM write data
o_sram_we_n  output  1  SRAM write enable, active-low
o_busy  output  1  high in any state other than IDLE and DONE
o_full  output  1  high in DONE (region exhausted)
o_overrun  output  1  sticky: a sample arrived while a write was in progress
o_rec_len  output  20  number of samples committed since last start

Behaviour:
- Reset values (asynchronous): state IDLE, o_sram_addr=ADDR_MIN, o_sram_data=0, o_sram_we_n=1, o_busy=0, o_full=0, o_overrun=0, o_rec_len=0.
- States: IDLE, WAIT, WRITE, HOLD, PAUSE, DONE.
- Control priority when pulses coincide in one cycle: stop > pause > start.
- IDLE:
  - o_sram_we_n=1; o_sram_addr is held at ADDR_MIN.
  - On i_start: go to WAIT; clear o_rec_len, o_overrun and o_full.
- WAIT:
  - On i_stop: go to IDLE.
  - Else on i_pause: go to PAUSE.
  - Else on i_data_valid: latch i_data into o_sram_data, go to WRITE, and drive o_sram_we_n=0 from the next cycle.
  - Latency: valid pulse at cycle n, so we_n=0 and data are valid at cycle n+1.
- WRITE:
  - o_sram_we_n=0 for exactly WE_CYCLES cycles; address and data stay stable.
  - Then go to HOLD.
- HOLD (one cycle):
  - o_sram_we_n=1; address and data unchanged (hold time).
  - o_rec_len <= o_sram_addr - ADDR_MIN + 1.
  - If o_sram_addr==ADDR_MAX: go to DONE; o_full=1; the address does not wrap.
  - Otherwise: o_sram_addr <= o_sram_addr+1.
  - Next state is resolved from pending control:
    - stop pending: IDLE, with o_sram_addr reset to ADDR_MIN.
    - pause pending: PAUSE.
    - otherwise: WAIT.
- Pulses during WRITE/HOLD:
  - i_stop or i_pause arriving during WRITE/HOLD is registered as pending and acted on at HOLD exit. A started write is never truncated.
  - i_data_valid during WRITE/HOLD drops the sample and sets o_overrun=1. o_overrun stays set until the next start from IDLE/DONE.
- PAUSE:
  - o_sram_we_n=1; address is retained; i_data_valid is ignored and does not set overrun.
  - i_start: go to WAIT.
  - i_stop: go to IDLE.
- DONE:
  - o_sram_we_n=1; i_data_valid is ignored.
  - i_start: restart from ADDR_MIN (same as start from IDLE).
  - i_stop: go to IDLE; o_full clears; o_rec_len is retained.
- o_rec_len is only cleared by a start from IDLE/DONE or by reset. Stop and pause retain it.
- Arithmetic: the address is unsigned 20-bit; the data path is a straight 16-bit copy with no scaling.
- Reset asserted mid-write forces o_sram_we_n=1 immediately (asynchronous).

Test Plan:
- Basic write:
  - Stimulus: reset, i_start, then valid pulses with data 16'h1234, 16'h8001, 16'h7FFF spaced 10 cycles apart.
  - Required: three we_n-low windows of exactly 2 cycles at addresses 0, 1, 2 with matching data; o_rec_len=3; o_busy=1.
- Pause/resume:
  - Stimulus: record 2 samples, i_pause, send 5 valid pulses, i_start, send 1 sample.
  - Required: no writes during pause; third sample lands at address 2; o_rec_len=3; o_overrun=0.
- Stop during write:
  - Stimulus: i_stop in the cycle after we_n falls.
  - Required: we_n stays low for the full 2 cycles, then a HOLD cycle, then IDLE with o_sram_addr=0 and o_rec_len=1.
- Region full:
  - Stimulus: ADDR_MAX=20'h3, send 6 samples.
  - Required: writes to addresses 0..3 only; o_full=1; o_rec_len=4; state DONE; addresses do not wrap. A following i_start restarts at address 0 with o_rec_len=0 and o_full=0.
- Overrun:
  - Stimulus: valid pulse at cycle n, second valid at n+2.
  - Required: second sample is not written; o_overrun=1 and stays set until the next i_start from IDLE.
- Async reset:
  - Stimulus: assert i_rst_n low while we_n=0.
  - Required: we_n=1, addr=0, rec_len=0, state IDLE in the same cycle.
